// File: rtl/pinball_game_ctrl.sv
// Pinball game sequencer: owns the game phase, ball count, score and power-up high score.
// Balls leave flight either by a scored hole or by the flight timer expiring.
module pinball_game_ctrl #(
  parameter int BALLS       = 8,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       launch,
  input  logic [7:0] hole,
  output logic [2:0] state,
  output logic [3:0] ball_num,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [2:0] last_hole,
  output logic       hit,
  output logic       game_over
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_GET   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    ball_reg, ball_next;
  logic [7:0]    score_reg, score_next;
  logic [7:0]    high_reg, high_next;
  logic [2:0]    last_reg, last_next;
  logic          hit_reg, hit_next;
  logic [TW-1:0] timer_reg, timer_next;

  logic       hole_any;
  logic [2:0] hole_idx;
  logic [8:0] score_sum;
  logic       timer_done;

  // Lowest set hole index wins when several pulse together.
  always_comb begin
    hole_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (hole[i]) hole_idx = 3'(i);
    end
  end

  assign hole_any   = |hole;
  assign score_sum  = {1'b0, score_reg} + {6'd0, hole_idx} + 9'd1;
  assign timer_done = (timer_reg == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_next = state_reg;
    ball_next  = ball_reg;
    score_next = score_reg;
    high_next  = high_reg;
    last_next  = last_reg;
    hit_next   = 1'b0;
    timer_next = timer_reg;
    case (state_reg)
      S_RESET: state_next = S_WAIT;
      S_WAIT: begin
        if (start) begin
          ball_next  = 4'(BALLS);
          score_next = 8'd0;
          state_next = S_START;
        end
      end
      S_START: begin
        if (launch) begin
          timer_next = '0;
          state_next = S_GET;
        end
      end
      S_GET: begin
        timer_next = timer_reg + 1'b1;
        if (hole_any) begin
          score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
          last_next  = hole_idx;
          hit_next   = 1'b1;
        end
        // A hole and timer expiry on the same edge count as one scored ball.
        if (hole_any || timer_done) begin
          ball_next  = ball_reg - 4'd1;
          state_next = (ball_reg == 4'd1) ? S_OVER : S_START;
        end
      end
      S_OVER: begin
        if (score_reg > high_reg) high_next = score_reg;
        if (start) begin
          ball_next  = 4'(BALLS);
          score_next = 8'd0;
          state_next = S_START;
        end
      end
      default: state_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_RESET;
      ball_reg  <= 4'(BALLS);
      score_reg <= 8'd0;
      high_reg  <= 8'd0;
      last_reg  <= 3'd0;
      hit_reg   <= 1'b0;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      ball_reg  <= ball_next;
      score_reg <= score_next;
      high_reg  <= high_next;
      last_reg  <= last_next;
      hit_reg   <= hit_next;
      timer_reg <= timer_next;
    end
  end

  assign state      = state_reg;
  assign ball_num   = ball_reg;
  assign score      = score_reg;
  assign high_score = high_reg;
  assign last_hole  = last_reg;
  assign hit        = hit_reg;
  assign game_over  = (state_reg == S_OVER);

endmodule

// File: tb/tb_pinball_game_ctrl.sv
// Directed bench: dut_a (BALLS=8) covers flow, scoring, timeout and ignore cases;
// dut_b (BALLS=2) covers game end, high score and mid-game reset.
module tb_pinball_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, start_a = 1'b0, launch_a = 1'b0;
  logic [7:0] hole_a = 8'd0;
  logic [2:0] state_a, last_a;
  logic [3:0] ball_a;
  logic [7:0] score_a, high_a;
  logic       hit_a, over_a;

  logic       rst_b = 1'b1, start_b = 1'b0, launch_b = 1'b0;
  logic [7:0] hole_b = 8'd0;
  logic [2:0] state_b, last_b;
  logic [3:0] ball_b;
  logic [7:0] score_b, high_b;
  logic       hit_b, over_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pinball_game_ctrl #(.BALLS(8), .TIMEOUT_CYC(16)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .launch(launch_a), .hole(hole_a),
    .state(state_a), .ball_num(ball_a), .score(score_a), .high_score(high_a),
    .last_hole(last_a), .hit(hit_a), .game_over(over_a)
  );

  pinball_game_ctrl #(.BALLS(2), .TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .launch(launch_b), .hole(hole_b),
    .state(state_b), .ball_num(ball_b), .score(score_b), .high_score(high_b),
    .last_hole(last_b), .hit(hit_b), .game_over(over_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_vec++; if (state_a !== 3'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", state_a); end
    n_vec++; if (ball_a !== 4'd8) begin n_err++; $display("FAIL rst_ball got %0d exp 8", ball_a); end
    n_vec++; if (score_a !== 8'd0 || high_a !== 8'd0 || last_a !== 3'd0) begin n_err++; $display("FAIL rst_regs got score %0d high %0d last %0d exp 0 0 0", score_a, high_a, last_a); end
    n_vec++; if (hit_a !== 1'b0 || over_a !== 1'b0) begin n_err++; $display("FAIL rst_flags got hit %0b over %0b exp 0 0", hit_a, over_a); end
    rst_a = 1'b0;
    #1;
    n_vec++; if (state_a !== 3'd0) begin n_err++; $display("FAIL rel_state got %0d exp 0", state_a); end
    tick();
    n_vec++; if (state_a !== 3'd1) begin n_err++; $display("FAIL wait_state got %0d exp 1", state_a); end
    $display("reset: state %0d ball %0d score %0d", state_a, ball_a, score_a);
  endtask

  task automatic test_wait_ignore();
    hole_a = 8'hFF; launch_a = 1'b1;
    tick();
    hole_a = 8'd0; launch_a = 1'b0;
    n_vec++; if (state_a !== 3'd1 || ball_a !== 4'd8 || score_a !== 8'd0 || hit_a !== 1'b0) begin n_err++; $display("FAIL wait_ign got st %0d ball %0d score %0d hit %0b exp 1 8 0 0", state_a, ball_a, score_a, hit_a); end
    $display("wait ignore: state %0d ball %0d score %0d", state_a, ball_a, score_a);
  endtask

  task automatic test_start();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_vec++; if (state_a !== 3'd2) begin n_err++; $display("FAIL start_state got %0d exp 2", state_a); end
    n_vec++; if (ball_a !== 4'd8 || score_a !== 8'd0) begin n_err++; $display("FAIL start_load got ball %0d score %0d exp 8 0", ball_a, score_a); end
    $display("start: state %0d ball %0d score %0d", state_a, ball_a, score_a);
  endtask

  task automatic test_scoring();
    launch_a = 1'b1;
    tick();
    launch_a = 1'b0;
    n_vec++; if (state_a !== 3'd3) begin n_err++; $display("FAIL launch_state got %0d exp 3", state_a); end
    hole_a = 8'b0000_0100;
    tick();
    hole_a = 8'd0;
    n_vec++; if (score_a !== 8'd3 || ball_a !== 4'd7) begin n_err++; $display("FAIL score_h2 got score %0d ball %0d exp 3 7", score_a, ball_a); end
    n_vec++; if (last_a !== 3'd2 || hit_a !== 1'b1 || state_a !== 3'd2) begin n_err++; $display("FAIL score_h2_flags got last %0d hit %0b st %0d exp 2 1 2", last_a, hit_a, state_a); end
    tick();
    n_vec++; if (hit_a !== 1'b0) begin n_err++; $display("FAIL hit_pulse got %0b exp 0", hit_a); end
    $display("scoring: score %0d ball %0d last %0d", score_a, ball_a, last_a);
  endtask

  task automatic test_simultaneous();
    launch_a = 1'b1;
    tick();
    launch_a = 1'b0;
    hole_a = 8'b1000_0010;
    tick();
    hole_a = 8'd0;
    n_vec++; if (score_a !== 8'd5 || ball_a !== 4'd6 || last_a !== 3'd1) begin n_err++; $display("FAIL simul got score %0d ball %0d last %0d exp 5 6 1", score_a, ball_a, last_a); end
    $display("simultaneous: score %0d ball %0d last %0d", score_a, ball_a, last_a);
  endtask

  task automatic test_timeout();
    launch_a = 1'b1;
    tick();
    launch_a = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    n_vec++; if (ball_a !== 4'd6 || state_a !== 3'd3) begin n_err++; $display("FAIL tmo_early got ball %0d st %0d exp 6 3", ball_a, state_a); end
    tick();
    n_vec++; if (ball_a !== 4'd5 || score_a !== 8'd5 || hit_a !== 1'b0 || state_a !== 3'd2) begin n_err++; $display("FAIL tmo_lost got ball %0d score %0d hit %0b st %0d exp 5 5 0 2", ball_a, score_a, hit_a, state_a); end
    $display("timeout lost: ball %0d score %0d", ball_a, score_a);
    launch_a = 1'b1;
    tick();
    launch_a = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    hole_a = 8'h01;
    tick();
    hole_a = 8'd0;
    n_vec++; if (ball_a !== 4'd4 || score_a !== 8'd6 || hit_a !== 1'b1 || last_a !== 3'd0) begin n_err++; $display("FAIL tmo_hole got ball %0d score %0d hit %0b last %0d exp 4 6 1 0", ball_a, score_a, hit_a, last_a); end
    $display("timeout vs hole: ball %0d score %0d", ball_a, score_a);
  endtask

  task automatic test_ignore();
    hole_a = 8'hFF; start_a = 1'b1;
    tick();
    hole_a = 8'd0; start_a = 1'b0;
    n_vec++; if (state_a !== 3'd2 || ball_a !== 4'd4 || score_a !== 8'd6 || hit_a !== 1'b0) begin n_err++; $display("FAIL start_ign got st %0d ball %0d score %0d hit %0b exp 2 4 6 0", state_a, ball_a, score_a, hit_a); end
    launch_a = 1'b1;
    tick();
    launch_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_vec++; if (state_a !== 3'd3 || ball_a !== 4'd4 || score_a !== 8'd6) begin n_err++; $display("FAIL get_start_ign got st %0d ball %0d score %0d exp 3 4 6", state_a, ball_a, score_a); end
    rst_a = 1'b1;
    #1;
    n_vec++; if (state_a !== 3'd0 || ball_a !== 4'd8 || score_a !== 8'd0 || last_a !== 3'd0) begin n_err++; $display("FAIL midget_rst got st %0d ball %0d score %0d last %0d exp 0 8 0 0", state_a, ball_a, score_a, last_a); end
    $display("ignore/reset: state %0d ball %0d score %0d", state_a, ball_a, score_a);
    tick();
    rst_a = 1'b0;
  endtask

  task automatic test_game_over();
    rst_b = 1'b0;
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    launch_b = 1'b1; tick(); launch_b = 1'b0;
    hole_b = 8'h80; tick(); hole_b = 8'd0;
    n_vec++; if (score_b !== 8'd8 || ball_b !== 4'd1 || state_b !== 3'd2) begin n_err++; $display("FAIL go_first got score %0d ball %0d st %0d exp 8 1 2", score_b, ball_b, state_b); end
    launch_b = 1'b1; tick(); launch_b = 1'b0;
    hole_b = 8'h10; tick(); hole_b = 8'd0;
    n_vec++; if (state_b !== 3'd4 || over_b !== 1'b1 || score_b !== 8'd13 || ball_b !== 4'd0) begin n_err++; $display("FAIL go_over got st %0d over %0b score %0d ball %0d exp 4 1 13 0", state_b, over_b, score_b, ball_b); end
    n_vec++; if (high_b !== 8'd0) begin n_err++; $display("FAIL go_high_early got %0d exp 0", high_b); end
    tick();
    n_vec++; if (high_b !== 8'd13) begin n_err++; $display("FAIL go_high got %0d exp 13", high_b); end
    hole_b = 8'h01; tick(); hole_b = 8'd0;
    n_vec++; if (state_b !== 3'd4 || score_b !== 8'd13 || ball_b !== 4'd0 || hit_b !== 1'b0) begin n_err++; $display("FAIL over_ign got st %0d score %0d ball %0d hit %0b exp 4 13 0 0", state_b, score_b, ball_b, hit_b); end
    $display("game over: score %0d high %0d", score_b, high_b);
    start_b = 1'b1; tick(); start_b = 1'b0;
    n_vec++; if (state_b !== 3'd2 || ball_b !== 4'd2 || score_b !== 8'd0) begin n_err++; $display("FAIL restart got st %0d ball %0d score %0d exp 2 2 0", state_b, ball_b, score_b); end
    for (int g = 0; g < 2; g++) begin
      launch_b = 1'b1; tick(); launch_b = 1'b0;
      hole_b = 8'h01; tick(); hole_b = 8'd0;
    end
    tick();
    n_vec++; if (state_b !== 3'd4 || score_b !== 8'd2 || high_b !== 8'd13) begin n_err++; $display("FAIL high_keep got st %0d score %0d high %0d exp 4 2 13", state_b, score_b, high_b); end
    $display("second game: score %0d high %0d", score_b, high_b);
    start_b = 1'b1; tick(); start_b = 1'b0;
    launch_b = 1'b1; tick(); launch_b = 1'b0;
    rst_b = 1'b1;
    #1;
    n_vec++; if (state_b !== 3'd0 || high_b !== 8'd0 || ball_b !== 4'd2 || over_b !== 1'b0) begin n_err++; $display("FAIL b_rst got st %0d high %0d ball %0d over %0b exp 0 0 2 0", state_b, high_b, ball_b, over_b); end
    $display("mid-game reset: state %0d high %0d", state_b, high_b);
  endtask

  initial begin
    test_reset();
    test_wait_ignore();
    test_start();
    test_scoring();
    test_simultaneous();
    test_timeout();
    test_ignore();
    test_game_over();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pinball_game_ctrl.md
# pinball_game_ctrl

Game sequencer for the pinball table. It drives the shared 3-bit game `state` bus that the ball sensor and display logic decode. It owns the authoritative ball count and score. It consumes one-pulse hole hits from the ball sensor plus player button pulses, and steps through reset, wait, launch, in-flight and game-over phases. It also handles lost-ball timeout and a per-power-up high score.

## Interface
- `BALLS`, default 8: balls per game, range 1..15.
- `TIMEOUT_CYC`, default 500_000_000: cycles a launched ball may stay in flight before it counts as lost. Minimum 2.
- `clk` input, 1 bit: system clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: one-cycle pulse from the debounced start button.
- `launch` input, 1 bit: one-cycle pulse from the debounced plunger/launch button.
- `hole` input, 8 bits: one-cycle pulses, bit i means a ball entered hole i.
- `state` output, 3 bits: RESET=0, WAIT=1, START=2, GET=3, OVER=4; registered.
- `ball_num` output, 4 bits: balls remaining in the current game.
- `score` output, 8 bits: current game score.
- `high_score` output, 8 bits: best completed-game score since reset.
- `last_hole` output, 3 bits: index of the most recent scored hole.
- `hit` output, 1 bit: one-cycle pulse when a hole is scored.
- `game_over` output, 1 bit: high while `state`==OVER.

## Operation
- States and transitions:
  - RESET: unconditionally goes to WAIT on the next edge.
  - WAIT: on `start`, loads `ball_num`=BALLS and `score`=0, then goes to START.
  - START: the ball is ready at the plunger. On `launch`, clears the flight timer and goes to GET.
  - GET: the ball is in flight.
    - On any `hole` bit set: decrement `ball_num`, add points, update `last_hole`, pulse `hit`.
    - On timer reaching TIMEOUT_CYC-1 with no hole: decrement `ball_num` only; no score, no `hit`.
    - After either event: if the new `ball_num`==0, go to OVER, otherwise go back to START.
  - OVER: `high_score` updates on entry if `score` > `high_score`. On `start`, reloads `ball_num`=BALLS and `score`=0 and goes directly to START. `score` and `ball_num` hold until then.
- Points: hole i is worth i+1 (1..8). Add with saturation at 255.
- Multiple `hole` bits in the same cycle count as one ball. The lowest set index scores.
- Hole pulses outside GET are ignored: no count change, no score.
- `launch` outside START is ignored.
- `start` in START or GET is ignored; there is no mid-game restart.
- Flight timer: counter of ceil(log2(TIMEOUT_CYC)) bits. It runs only in GET, is cleared on GET entry, and holds in other states.

## Timing
- Reset values:
  - `state`=RESET(0), `ball_num`=BALLS, `score`=0, `high_score`=0, `last_hole`=0, `hit`=0, `game_over`=0, timer=0.
- Asynchronous assertion of `rst` forces these values immediately, even mid-game. Deassertion is sampled on the next edge; RESET then lasts exactly one cycle before WAIT.
- All outputs are registered. Input seen at edge N means the effect is visible after edge N, i.e. latency 1.
- A hole pulse at edge N updates all of these together after edge N: `ball_num`, `score`, `last_hole`, `hit`=1 for one cycle, and `state` (START or OVER).
- `high_score` updates one cycle after OVER entry.
- Timeout: a ball launched at edge L with no hole is counted lost at edge L+TIMEOUT_CYC.
- A hole pulse and timeout expiry in the same cycle: the hole wins and scores.
- `launch` on the same edge the controller returns to START is not accepted. A launch is accepted only when `state`==START is already visible.

## Test plan
1. Reset and start: assert `rst`, release, pulse `start`. Expect `state` 0→1 after one cycle, then 2. Expect `ball_num`=8 and `score`=0.
2. Scoring: launch, then pulse `hole`=8'b0000_0100. Expect `score`=3, `ball_num`=7, `last_hole`=2, `hit` high for one cycle, `state`=START.
3. Simultaneous holes: in GET, pulse `hole`=8'b1000_0010. Expect `score`+=2, `ball_num`-=1 exactly once, `last_hole`=1.
4. Lost ball, with TIMEOUT_CYC=16: launch and send no hole. Expect `ball_num` to decrement at exactly launch+16, `score` unchanged, `hit` low. A hole on cycle 16 scores instead.
5. Game end and high score, with BALLS=2: score 8 then 5. Expect `state`=OVER and `game_over`=1, then `high_score`=13. Restart and score 1+1: expect `high_score` to stay 13.
6. Ignore and reset cases:
   - Hole pulses in WAIT, START and OVER: no change.
   - `start` during GET: no change.
   - `rst` asserted mid-GET: all outputs return to reset values immediately, including `high_score`=0.
